// File: rtl/pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen_if
// Description : Request / serial-stream bundle between a pattern_gen and
//               whoever drives it. The master side requests frames; the slave
//               side (pattern_gen) emits the serial stream and status flags.
//               The stop signal exists only with PATTERN_GEN_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [3:0]       len;
  logic [3:0]       reps;
`ifdef PATTERN_GEN_LOOP_EN
  logic             stop;
`endif
  logic             w;
  logic             busy;
  logic             done;
  logic             bit_valid;

`ifdef PATTERN_GEN_LOOP_EN
  modport master (output start, pattern, len, reps, stop,
                  input  w, busy, done, bit_valid);
  modport slave  (input  start, pattern, len, reps, stop,
                  output w, busy, done, bit_valid);
`else
  modport master (output start, pattern, len, reps,
                  input  w, busy, done, bit_valid);
  modport slave  (input  start, pattern, len, reps,
                  output w, busy, done, bit_valid);
`endif
endinterface
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen
// Description : Serial frame generator. On start (sampled in IDLE) it captures
//               pattern/len/reps and shifts the pattern out MSB first on w for
//               the effective length, repeating reps+1 times with GAP_CYCLES
//               idle-low cycles between frames, then pulses done.
//               Optional feature macro: PATTERN_GEN_LOOP_EN adds a stop input
//               and makes reps=4'hF repeat until stop.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  pattern_gen_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [CW-1:0]    eff_q,   eff_d;
  logic [CW-1:0]    bits_q,  bits_d;   // bits still to send after the one on w
  logic [3:0]       reps_q,  reps_d;   // frames still to send after this one
  logic [GW-1:0]    gap_q,   gap_d;    // gap cycles left after the current one
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bv_q, bv_d;

  logic             load;              // start a frame from src/src_len
  logic [WIDTH-1:0] src;
  logic [CW-1:0]    src_len;
  logic             more_frames;
  logic             dec_reps;
  logic             gap_stop;

  // Effective frame length: len=0 or len beyond the register means full width
  function automatic logic [CW-1:0] eff_of(input logic [3:0] l);
    if (l == 4'd0 || int'(l) > WIDTH) return CW'(WIDTH);
    return CW'(l);
  endfunction

`ifdef PATTERN_GEN_LOOP_EN
  logic inf_q, inf_d;                  // reps=15 captured: run until stop
  logic stop_pend_q, stop_pend_d;      // stop seen during the current frame

  assign more_frames = inf_q ? !(stop_pend_q || bus.stop) : (reps_q != 4'd0);
  assign dec_reps    = !inf_q;
  assign gap_stop    = inf_q && bus.stop;

  // Loop-mode bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inf_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      inf_q       <= inf_d;
      stop_pend_q <= stop_pend_d;
    end
  end
`else
  assign more_frames = (reps_q != 4'd0);
  assign dec_reps    = 1'b1;
  assign gap_stop    = 1'b0;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      eff_q   <= '0;
      bits_q  <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      eff_q   <= eff_d;
      bits_q  <= bits_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bv_q    <= bv_d;
    end
  end

  // Next-state and next-output logic; outputs describe the coming cycle
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    eff_d   = eff_q;
    bits_d  = bits_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    w_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bv_d    = 1'b0;
    load    = 1'b0;
    src     = pat_q;
    src_len = eff_q;
`ifdef PATTERN_GEN_LOOP_EN
    inf_d       = inf_q;
    stop_pend_d = stop_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          eff_d   = eff_of(bus.len);
          reps_d  = bus.reps;
          src     = bus.pattern;
          src_len = eff_of(bus.len);
          load    = 1'b1;
`ifdef PATTERN_GEN_LOOP_EN
          inf_d       = (bus.reps == 4'hF);
          stop_pend_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
`ifdef PATTERN_GEN_LOOP_EN
        if (inf_q && bus.stop) stop_pend_d = 1'b1;
`endif
        if (bits_q != '0) begin
          w_d     = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          bits_d  = bits_q - CW'(1);
          bv_d    = 1'b1;
          busy_d  = 1'b1;
        end else if (more_frames) begin
          if (dec_reps) reps_d = reps_q - 4'd1;
          if (GAP_CYCLES == 0) begin
            load = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = c_GAP_LAST;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_stop) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (gap_q != '0) begin
          gap_d  = gap_q - GW'(1);
          busy_d = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame (re)load: first bit goes straight onto w, the rest into shreg
    if (load) begin
      state_d = S_SHIFT;
      w_d     = src[WIDTH-1];
      shreg_d = src << 1;
      bits_d  = src_len - CW'(1);
      bv_d    = 1'b1;
      busy_d  = 1'b1;
    end
  end

  assign bus.w         = w_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bit_valid = bv_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_gen
// Description : Self-checking bench for pattern_gen. Two instances share the
//               stimulus: one with GAP_CYCLES=2, one with GAP_CYCLES=0.
//               Vector table plus hand sequences for reset abort, a
//               three-ones detector on w, and loop/stop mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_gen_if #(.WIDTH(8)) ifc ();
  pattern_gen_if #(.WIDTH(8)) if0 ();

  assign if0.start   = ifc.start;
  assign if0.pattern = ifc.pattern;
  assign if0.len     = ifc.len;
  assign if0.reps    = ifc.reps;
`ifdef PATTERN_GEN_LOOP_EN
  assign if0.stop    = ifc.stop;
`endif

  pattern_gen #(.WIDTH(8), .GAP_CYCLES(2)) u_dut  (.clk(clk), .reset(reset), .bus(ifc));
  pattern_gen #(.WIDTH(8), .GAP_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference three-consecutive-ones detector fed by w
  int   det_cnt;
  logic det_out;
  always @(posedge clk or posedge reset) begin
    if (reset)      det_cnt <= 0;
    else if (ifc.w) det_cnt <= (det_cnt < 3) ? det_cnt + 1 : 3;
    else            det_cnt <= 0;
  end
  assign det_out = (det_cnt >= 3);

  typedef struct packed {
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] reps;
    logic [7:0] exp_bits;   // frame bits, bit nbits-1 sent first
    logic [4:0] nbits;
    logic [4:0] nframes;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string build_stream(input vec_t v, input int gap);
    string s = "";
    for (int f = 0; f < int'(v.nframes); f++) begin
      if (f > 0) for (int g = 0; g < gap; g++) s = {s, "g"};
      for (int b = int'(v.nbits) - 1; b >= 0; b--) s = {s, v.exp_bits[b] ? "1" : "0"};
    end
    return s;
  endfunction

  // Expected {w, bit_valid, busy, done} in cycle k (cycle 1 = first bit)
  function automatic logic [3:0] exp_at(input string s, input int k);
    int L = s.len();
    if (k <= L) begin
      if (s[k-1] == "g")      return 4'b0010;
      else if (s[k-1] == "1") return 4'b1110;
      else                    return 4'b0110;
    end
    if (k == L + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    string s2, s0;
    int    kmax;
    s2   = build_stream(v, 2);
    s0   = build_stream(v, 0);
    kmax = ((s2.len() > s0.len()) ? s2.len() : s0.len()) + 2;
    @(negedge clk);
    ifc.pattern = v.pat;
    ifc.len     = v.len;
    ifc.reps    = v.reps;
    ifc.start   = 1'b1;
    @(posedge clk); #1;
    ifc.start   = 1'b0;
    // scramble inputs after capture; they must not matter
    ifc.pattern = ~v.pat;
    ifc.len     = v.len + 4'd3;
    ifc.reps    = v.reps ^ 4'h5;
    for (int k = 1; k <= kmax; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      ifc.start = (k == 2);   // sampled while busy or in DONE: must be ignored
      check($sformatf("v%0d.k%0d.gap2", id, k),
            {28'd0, ifc.w, ifc.bit_valid, ifc.busy, ifc.done}, {28'd0, exp_at(s2, k)});
      check($sformatf("v%0d.k%0d.gap0", id, k),
            {28'd0, if0.w, if0.bit_valid, if0.busy, if0.done}, {28'd0, exp_at(s0, k)});
    end
    ifc.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pat:8'hB0, len:4'd4,  reps:4'd0,  exp_bits:8'b0000_1011, nbits:5'd4, nframes:5'd1};
    vecs[1] = '{pat:8'hA5, len:4'd0,  reps:4'd1,  exp_bits:8'b1010_0101, nbits:5'd8, nframes:5'd2};
    vecs[2] = '{pat:8'h3C, len:4'd12, reps:4'd0,  exp_bits:8'b0011_1100, nbits:5'd8, nframes:5'd1};
    vecs[3] = '{pat:8'hE0, len:4'd3,  reps:4'd0,  exp_bits:8'b0000_0111, nbits:5'd3, nframes:5'd1};
    vecs[4] = '{pat:8'h80, len:4'd1,  reps:4'd2,  exp_bits:8'b0000_0001, nbits:5'd1, nframes:5'd3};
    vecs[5] = '{pat:8'h5A, len:4'd8,  reps:4'd0,  exp_bits:8'b0101_1010, nbits:5'd8, nframes:5'd1};
    vecs[6] = '{pat:8'hC3, len:4'd15, reps:4'd15, exp_bits:8'b1100_0011, nbits:5'd8, nframes:5'd16};
    vecs[7] = '{pat:8'hFF, len:4'd1,  reps:4'd15, exp_bits:8'b0000_0001, nbits:5'd1, nframes:5'd16};
    vecs[8] = '{pat:8'h6E, len:4'd7,  reps:4'd0,  exp_bits:8'b0011_0111, nbits:5'd7, nframes:5'd1};

    ifc.start   = 1'b0;
    ifc.pattern = 8'h00;
    ifc.len     = 4'd0;
    ifc.reps    = 4'd0;
`ifdef PATTERN_GEN_LOOP_EN
    ifc.stop    = 1'b0;
`endif

    // Reset state
    reset = 1'b1;
    #1;
    check("reset.outs", {28'd0, ifc.w, ifc.bit_valid, ifc.busy, ifc.done}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle.outs", {28'd0, ifc.w, ifc.bit_valid, ifc.busy, ifc.done}, 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
`ifdef PATTERN_GEN_LOOP_EN
      if (vecs[i].reps == 4'hF) continue;
`endif
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a frame aborts it asynchronously
    @(negedge clk);
    ifc.pattern = 8'hFF;
    ifc.len     = 4'd8;
    ifc.reps    = 4'd1;
    ifc.start   = 1'b1;
    @(posedge clk); #1;
    ifc.start   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.pre_busy", {31'd0, ifc.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort.async2", {29'd0, ifc.w, ifc.bit_valid, ifc.busy}, 32'd0);
    check("abort.async0", {29'd0, if0.w, if0.bit_valid, if0.busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen_done = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (ifc.done || if0.done || ifc.busy || if0.busy) seen_done++;
      end
      check("abort.no_done", seen_done, 32'd0);
    end
    run_vec(9, vecs[0]);   // first start after reset is accepted

    // Detector driven by w: 1,1,1 then 0
    @(negedge clk);
    ifc.pattern = 8'hE0;
    ifc.len     = 4'd3;
    ifc.reps    = 4'd0;
    ifc.start   = 1'b1;
    @(posedge clk); #1;
    ifc.start   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check($sformatf("det.k%0d", k), {31'd0, det_out}, (k == 4) ? 32'd1 : 32'd0);
    end

`ifdef PATTERN_GEN_LOOP_EN
    // Infinite repeat, stop raised during frame 5 of the gapped instance
    begin
      int bits2 = 0, bits0 = 0, done2 = -1, done0 = -1;
      @(negedge clk);
      ifc.pattern = 8'h80;
      ifc.len     = 4'd2;
      ifc.reps    = 4'hF;
      ifc.start   = 1'b1;
      @(posedge clk); #1;
      ifc.start   = 1'b0;
      for (int k = 1; k <= 200; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        ifc.stop = (k == 17);
        if (ifc.bit_valid) bits2++;
        if (if0.bit_valid) bits0++;
        if (ifc.done && done2 < 0) done2 = k;
        if (if0.done && done0 < 0) done0 = k;
      end
      ifc.stop = 1'b0;
      check("loop.frames2", bits2 / 2, 32'd5);
      check("loop.frames0", bits0 / 2, 32'd9);
      check("loop.done2",   done2, 32'd19);
      check("loop.done0",   done0, 32'd19);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
